// File: rtl/data_ram_resp_pkg.sv
// data_ram_resp_pkg: shared bus types, FSM state encoding and the address
// error check used by the data-memory responder.
package data_ram_resp_pkg;

  typedef logic [31:0] data_addr_bus_t;
  typedef logic [31:0] data_bus_t;
  typedef logic [3:0]  byte_sel_bus_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam int unsigned CNT_W = 4;

  // Misaligned word access, or any byte-address bit above the RAM span set.
  function automatic logic addr_err(input data_addr_bus_t a, input int unsigned aw);
    data_addr_bus_t hi;
    hi = a >> (aw + 2);
    return (a[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// data_ram_array: 2^ADDR_WIDTH x 32-bit storage.
//   clk      - clock
//   i_rst    - synchronous reset of the read-data register only
//   i_we     - write strobe, qualified per byte by i_sel
//   i_sel    - byte-lane enables (bit 3 = data[31:24])
//   i_addr   - word address
//   i_wdata  - write data
//   i_re     - read strobe; when low the read register loads zero
//   o_rdata  - registered read data
module data_ram_array
  import data_ram_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  byte_sel_bus_t         i_sel,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  data_bus_t             i_wdata,
  input  logic                  i_re,
  output data_bus_t             o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] r_mem [DEPTH];
  data_bus_t   r_rdata;

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (i_we && i_sel[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Cleared whenever no load completes, so the output is zero outside load acks.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end else begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_ram_resp.sv
// data_ram_resp: data-memory responder for the CPU core's memory stage.
// Accepts load/store requests, waits WAIT_STATES cycles, performs the access
// and returns a one-cycle acknowledge with read data and an error flag.
//   clk, rst     - clock, synchronous active-high reset
//   ram_ce_i     - request valid, held until the ack cycle
//   ram_we_i     - 1 = store, 0 = load
//   ram_sel_i    - store byte enables
//   ram_addr_i   - byte address
//   ram_data_i   - store data
//   ram_data_o   - load data (valid with ack)
//   ram_ack_o    - completion pulse
//   ram_err_o    - access error, qualified by ack
//   ram_stall_o  - combinational stall request to the core
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ram_ce_i,
  input  logic           ram_we_i,
  input  byte_sel_bus_t  ram_sel_i,
  input  data_addr_bus_t ram_addr_i,
  input  data_bus_t      ram_data_i,
  output data_bus_t      ram_data_o,
  output logic           ram_ack_o,
  output logic           ram_err_o,
  output logic           ram_stall_o
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);
  localparam logic NO_WAIT = (WAIT_STATES == 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  byte_sel_bus_t    r_sel;
  data_addr_bus_t   r_addr;
  data_bus_t        r_wdata;
  logic             r_ack;
  logic             r_err;

  logic             w_accept;
  logic             w_go_ack;
  logic             w_from_wait;
  logic             w_acc_we;
  byte_sel_bus_t    w_acc_sel;
  data_addr_bus_t   w_acc_addr;
  data_bus_t        w_acc_wdata;
  logic             w_acc_err;
  logic             w_mem_we;
  logic             w_mem_re;

  assign w_accept    = ram_ce_i && ((r_state == S_IDLE) || (r_state == S_ACK));
  assign w_from_wait = (r_state == S_WAIT);

  // The access happens on the edge entering ACK. With no wait states that is
  // the acceptance edge itself, so the live inputs are used instead of the
  // captured copies.
  assign w_go_ack = (w_from_wait && ram_ce_i && (r_cnt == '0)) ||
                    (w_accept && NO_WAIT);

  always_comb begin
    w_acc_we    = ram_we_i;
    w_acc_sel   = ram_sel_i;
    w_acc_addr  = ram_addr_i;
    w_acc_wdata = ram_data_i;
    if (w_from_wait) begin
      w_acc_we    = r_we;
      w_acc_sel   = r_sel;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
    end
  end

  assign w_acc_err = addr_err(w_acc_addr, ADDR_WIDTH);
  // Array writes are not reset, so reset must gate the strobe directly.
  assign w_mem_we  = w_go_ack && w_acc_we && !w_acc_err && !rst;
  assign w_mem_re  = w_go_ack && !w_acc_we && !w_acc_err;

  data_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .i_rst   (rst),
    .i_we    (w_mem_we),
    .i_sel   (w_acc_sel),
    .i_addr  (w_acc_addr[ADDR_WIDTH+1:2]),
    .i_wdata (w_acc_wdata),
    .i_re    (w_mem_re),
    .o_rdata (ram_data_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= w_go_ack;
      r_err <= w_go_ack && w_acc_err;
      case (r_state)
        S_IDLE, S_ACK: begin
          if (ram_ce_i) begin
            r_we    <= ram_we_i;
            r_sel   <= ram_sel_i;
            r_addr  <= ram_addr_i;
            r_wdata <= ram_data_i;
            if (NO_WAIT) begin
              r_state <= S_ACK;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (!ram_ce_i) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_state <= S_ACK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ram_ack_o   = r_ack;
  assign ram_err_o   = r_err;
  assign ram_stall_o = ram_ce_i && !r_ack;

endmodule

// File: doc/data_ram_resp.md
# data_ram_resp

Responder for the CPU core's data-memory port: accepts load/store requests from the core's memory stage, models a RAM with a configurable number of wait states, stalls the core until the access completes, and returns read data with a one-cycle acknowledge. It sits beside the instruction ROM in the SoC top and is the slave end of the core's data bus.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; capacity 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, default 2: extra cycles between acceptance and acknowledge; legal range 0..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `ram_ce_i` in 1: request valid; held by the core until the acknowledge cycle.
- `ram_we_i` in 1: 1 = store, 0 = load.
- `ram_sel_i` in 4: byte enables; bit 3 = data[31:24] … bit 0 = data[7:0].
- `ram_addr_i` in 32: byte address.
- `ram_data_i` in 32: store data.
- `ram_data_o` out 32: load data; valid only while `ram_ack_o` = 1.
- `ram_ack_o` out 1: one-cycle completion pulse.
- `ram_err_o` out 1: access error; qualified by `ram_ack_o`.
- `ram_stall_o` out 1: stall request to the core pipeline.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE, `ram_ce_i`=1: capture we/sel/addr/data; go to WAIT with `cnt` = WAIT_STATES-1, or to ACK directly if WAIT_STATES = 0.
- WAIT: `cnt` decrements; at `cnt` = 0 go to ACK. If `ram_ce_i` drops in WAIT, abort: back to IDLE, no memory write, no ack.
- The memory access happens on the edge entering ACK:
  - Stores write the enabled byte lanes only.
  - Loads register the full word into `ram_data_o`. `sel` is ignored for loads; the core extracts bytes itself.
- ACK: `ram_ack_o`=1 for exactly one cycle. Next state:
  - `ram_ce_i`=1 (the core has advanced to a new request): capture it and go to WAIT/ACK, as from IDLE.
  - otherwise: IDLE.
- Error: the captured address has addr[1:0] ≠ 0, or any address bit above ADDR_WIDTH+1 set.
  - `ram_err_o`=1 with the ack.
  - Store suppressed.
  - `ram_data_o` = 0.
- `ram_stall_o` = `ram_ce_i` & ~`ram_ack_o` (combinational), so the core stalls from the request cycle up to, but not including, the ack cycle.
- Inputs that change after capture are ignored until the next acceptance.

## Timing
- Reset values: `ram_data_o`=0, `ram_ack_o`=0, `ram_err_o`=0, state IDLE, `cnt`=0. `ram_stall_o` follows `ram_ce_i` during reset.
- Latency: request accepted in cycle 0 → ack in cycle WAIT_STATES+1. Throughput is one access per WAIT_STATES+1 cycles under back-to-back requests.
- Reset asserted mid-request: the pending store is discarded and no ack is issued. Memory contents are not cleared.
- A load issued in the cycle after a store ack to the same word returns the new data; there is no read-before-write hazard.
- `ram_data_o`, `ram_ack_o` and `ram_err_o` are registered. Only `ram_stall_o` is combinational.

## Structure
- Shared defines header: `data_addr_bus` (31:0), `data_bus` (31:0), `byte_sel_bus` (3:0), and the FSM state encodings.
- One sub-module, `data_ram_array`: 2^ADDR_WIDTH × 32 storage with a per-byte write-enable and a synchronous read port. The FSM, counter and error check stay in `data_ram_resp`.

## Test plan
- WAIT_STATES=2; store 0xDEADBEEF to 0x10 with sel=4'b1111, then load 0x10 → ack in cycle 3 of each access, load data 0xDEADBEEF; stall high for cycles 0–2 and low in cycle 3.
- Store 0x000000AA to 0x10 with sel=4'b0001 over 0xDEADBEEF, then load → 0xDEADBEAA.
- Load from 0x13 (misaligned) and from 0x0000_1000 (out of range at ADDR_WIDTH=10) → ack with err=1, data 0; a follow-up load of the target word is unchanged.
- Drop `ram_ce_i` in the WAIT cycle of a store of 0x12345678 to 0x20 → no ack, FSM in IDLE; a later load of 0x20 returns the old value.
- Assert `rst` for one cycle during WAIT of a store → no ack, outputs 0, store not performed. Previously written word 0x10 still reads 0xDEADBEAA.
- WAIT_STATES=0, four back-to-back loads with `ram_ce_i` held high → ack in every cycle from cycle 1, with addresses advancing each ack.
